// File: rtl/rr_merge2_pkg.sv
// Shared constants and the round-robin pick rule for the two-lane stream merge.
package rr_merge2_pkg;

    localparam logic SRC_LANE0      = 1'b0;
    localparam logic SRC_LANE1      = 1'b1;
    // Lane 1 counts as last served out of reset, so lane 0 wins the first contention.
    localparam logic LAST_GRANT_RST = SRC_LANE1;

    // Contention alternates away from the last winner; with no request the select parks.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        if (v0)       return SRC_LANE0;
        if (v1)       return SRC_LANE1;
        return last;
    endfunction

endpackage

// File: rtl/selectMux2.sv
// Two-way word select used as the steering datapath of rr_merge2.
module selectMux2 #(
    parameter int N = 18
) (
    input  logic [N-1:0] in0_i,
    input  logic [N-1:0] in1_i,
    input  logic         sel_i,
    output logic [N-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/rr_merge2.sv
// Two-input valid/ready merge: round-robin arbiter steering selectMux2 into one output register.
module rr_merge2
    import rr_merge2_pkg::*;
#(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in0,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [N-1:0] in1,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [N-1:0] out,
    output logic         out_src,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [N-1:0] out_q, out_d;
    logic         out_src_q, out_src_d;
    logic         out_valid_q, out_valid_d;
    logic         last_grant_q, last_grant_d;

    logic         can_load;
    logic         any_valid;
    logic         grant;
    logic [N-1:0] sel_word;

    always_comb begin
        any_valid = in0_valid | in1_valid;
        can_load  = ~out_valid_q | out_ready;
        grant     = rr_pick(in0_valid, in1_valid, last_grant_q);
    end

    selectMux2 #(.N(N)) u_sel (
        .in0_i (in0),
        .in1_i (in1),
        .sel_i (grant),
        .out_o (sel_word)
    );

    // Readies are held low during reset so no handshake is reported mid-reset.
    assign in0_ready = ~rst & can_load & in0_valid & (grant == SRC_LANE0);
    assign in1_ready = ~rst & can_load & in1_valid & (grant == SRC_LANE1);

    always_comb begin
        out_d        = out_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (can_load) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_d        = sel_word;
                out_src_d    = grant;
                last_grant_d = grant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            out_src_q    <= SRC_LANE0;
            out_valid_q  <= 1'b0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            out_q        <= out_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out       = out_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule
